// File: rtl/csr_row_encoder.sv
// Dense-to-CSR row encoder: takes one dense row per handshake and emits one beat
// per nonzero element, or a single marker beat when the row is empty.
module csr_row_encoder #(
  parameter int N          = 5,
  parameter int ROWS       = 5,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0][DATA_WIDTH-1:0]   in_data_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  output logic [DATA_WIDTH-1:0]          out_data_o,
  output logic [ADDR_WIDTH-1:0]          out_col_o,
  output logic [ADDR_WIDTH-1:0]          out_row_o,
  output logic [ADDR_WIDTH-1:0]          out_idx_o,
  output logic                           out_empty_o,
  output logic                           out_row_last_o,
  output logic                           out_mat_last_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e                         state_q, state_d;
  logic [N-1:0][DATA_WIDTH-1:0]   row_q, row_d;
  logic [N-1:0]                   mask_q, mask_d;
  logic [ADDR_WIDTH-1:0]          row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0]          nnz_cnt_q, nnz_cnt_d;
  logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]          out_col_q, out_col_d;
  logic [ADDR_WIDTH-1:0]          out_row_q, out_row_d;
  logic [ADDR_WIDTH-1:0]          out_idx_q, out_idx_d;
  logic                           out_empty_q, out_empty_d;
  logic                           out_row_last_q, out_row_last_d;
  logic                           out_mat_last_q, out_mat_last_d;
  logic                           out_valid_q, out_valid_d;
  logic                           load_beat;
  int                             sel;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d        = state_q;
    row_d          = row_q;
    mask_d         = mask_q;
    row_cnt_d      = row_cnt_q;
    nnz_cnt_d      = nnz_cnt_q;
    out_data_d     = out_data_q;
    out_col_d      = out_col_q;
    out_row_d      = out_row_q;
    out_idx_d      = out_idx_q;
    out_empty_d    = out_empty_q;
    out_row_last_d = out_row_last_q;
    out_mat_last_d = out_mat_last_q;
    out_valid_d    = out_valid_q;
    load_beat      = 1'b0;
    sel            = 0;

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          row_d = in_data_i;
          for (int j = 0; j < N; j++) mask_d[j] = |in_data_i[j];
          state_d   = SCAN;
          load_beat = 1'b1;
        end
      end
      SCAN: begin
        if (out_ready_i) begin
          if (!out_empty_q) begin
            // The presented beat is always the lowest set bit, so clear it arithmetically.
            mask_d    = mask_q & (mask_q - 1'b1);
            nnz_cnt_d = nnz_cnt_q + ADDR_WIDTH'(1);
          end
          if (out_row_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            if (out_mat_last_q) begin
              row_cnt_d = '0;
              nnz_cnt_d = '0;
            end else begin
              row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
            end
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_beat) begin
      for (int j = N - 1; j >= 0; j--) begin
        if (mask_d[j]) sel = j;
      end
      out_valid_d    = 1'b1;
      out_empty_d    = (mask_d == '0);
      out_data_d     = out_empty_d ? '0 : row_d[sel];
      out_col_d      = out_empty_d ? '0 : ADDR_WIDTH'(sel);
      out_idx_d      = nnz_cnt_d;
      out_row_d      = row_cnt_q;
      out_row_last_d = ((mask_d & (mask_d - 1'b1)) == '0);
      out_mat_last_d = out_row_last_d && (row_cnt_q == ADDR_WIDTH'(ROWS - 1));
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      row_q          <= '0;
      mask_q         <= '0;
      row_cnt_q      <= '0;
      nnz_cnt_q      <= '0;
      out_data_q     <= '0;
      out_col_q      <= '0;
      out_row_q      <= '0;
      out_idx_q      <= '0;
      out_empty_q    <= 1'b0;
      out_row_last_q <= 1'b0;
      out_mat_last_q <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      mask_q         <= mask_d;
      row_cnt_q      <= row_cnt_d;
      nnz_cnt_q      <= nnz_cnt_d;
      out_data_q     <= out_data_d;
      out_col_q      <= out_col_d;
      out_row_q      <= out_row_d;
      out_idx_q      <= out_idx_d;
      out_empty_q    <= out_empty_d;
      out_row_last_q <= out_row_last_d;
      out_mat_last_q <= out_mat_last_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign in_ready_o     = (state_q == IDLE);
  assign out_data_o     = out_data_q;
  assign out_col_o      = out_col_q;
  assign out_row_o      = out_row_q;
  assign out_idx_o      = out_idx_q;
  assign out_empty_o    = out_empty_q;
  assign out_row_last_o = out_row_last_q;
  assign out_mat_last_o = out_mat_last_q;
  assign out_valid_o    = out_valid_q;

endmodule
